// File: rtl/aes_round_key_bank_if.sv
// aes_round_key_bank_if
// Key-broadcast and round-key read bus between the AES controller (master)
// and the round key bank (slave).
//   key_in / set_key_onehot : round key broadcast, one-hot strobe selects index
//   rd_req / rd_round / rd_dir : read request, round index, 0=enc 1=dec order
//   rd_key / rd_key_valid / rd_err : registered read response
//   keys_ready / sched_err / key_epoch : schedule status
interface aes_round_key_bank_if #(
    parameter int NUM_ROUNDS = 10
);
    logic [127:0]          key_in;
    logic [NUM_ROUNDS:0]   set_key_onehot;
    logic                  rd_req;
    logic [3:0]            rd_round;
    logic                  rd_dir;
    logic [127:0]          rd_key;
    logic                  rd_key_valid;
    logic                  rd_err;
    logic                  keys_ready;
    logic                  sched_err;
    logic [3:0]            key_epoch;

    modport master (
        output key_in, set_key_onehot, rd_req, rd_round, rd_dir,
        input  rd_key, rd_key_valid, rd_err, keys_ready, sched_err, key_epoch
    );

    modport slave (
        input  key_in, set_key_onehot, rd_req, rd_round, rd_dir,
        output rd_key, rd_key_valid, rd_err, keys_ready, sched_err, key_epoch
    );
endinterface

// File: rtl/aes_round_key_bank.sv
// aes_round_key_bank
// Captures AES-128 round keys broadcast by the controller under a one-hot
// strobe, checks they arrive in order 0..NUM_ROUNDS, stores them and serves
// any key in encryption or decryption order through a registered read port.
// Every completed schedule bumps a 4-bit epoch counter.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_round_key_bank_if slave modport (broadcast, read, status)
module aes_round_key_bank #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_key_bank_if.slave   bus
);

    localparam int            NK       = NUM_ROUNDS + 1;
    localparam logic [3:0]    LAST_IDX = 4'(NUM_ROUNDS);
    localparam logic [NK-1:0] ONE_NK   = {{(NK-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    // More than one strobe bit set: v & (v-1) keeps any bit beyond the lowest.
    function automatic logic is_multi_hot(input logic [NK-1:0] v);
        return |(v & (v - ONE_NK));
    endfunction

    // Index of the set bit; only meaningful when exactly one bit is set.
    function automatic logic [3:0] onehot_index(input logic [NK-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < NK; i++) begin
            if (v[i]) begin
                idx = idx | i[3:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [3:0]     exp_idx_r, exp_idx_nxt_s;
    logic           keys_ready_r, keys_ready_nxt_s;
    logic           sched_err_r, sched_err_nxt_s;
    logic [3:0]     key_epoch_r, key_epoch_nxt_s;
    logic           wr_en_s;
    logic [3:0]     wr_idx_s;
    logic           strobe_any_s;
    logic           strobe_multi_s;

    logic [127:0]   rk_r [0:NK-1];

    logic           rd_accept_s;
    logic           rd_oor_s;
    logic [3:0]     rd_addr_s;
    logic [127:0]   rd_key_r;
    logic           rd_key_valid_r;
    logic           rd_err_r;

    assign strobe_any_s   = |bus.set_key_onehot;
    assign strobe_multi_s = is_multi_hot(bus.set_key_onehot);
    assign wr_idx_s       = onehot_index(bus.set_key_onehot);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Strobe classification, next state and next status values.
    always_comb begin
        state_nxt_s      = state_r;
        exp_idx_nxt_s    = exp_idx_r;
        keys_ready_nxt_s = keys_ready_r;
        sched_err_nxt_s  = sched_err_r;
        key_epoch_nxt_s  = key_epoch_r;
        wr_en_s          = 1'b0;
        if (strobe_multi_s) begin
            state_nxt_s      = ST_ERROR;
            keys_ready_nxt_s = 1'b0;
            sched_err_nxt_s  = 1'b1;
        end else if (strobe_any_s) begin
            if (wr_idx_s == 4'd0) begin
                // Bit 0 restarts a schedule from any state, including ERROR.
                wr_en_s          = 1'b1;
                exp_idx_nxt_s    = 4'd1;
                state_nxt_s      = ST_LOADING;
                keys_ready_nxt_s = 1'b0;
                sched_err_nxt_s  = 1'b0;
            end else if ((state_r == ST_LOADING) && (wr_idx_s == exp_idx_r)) begin
                wr_en_s       = 1'b1;
                exp_idx_nxt_s = exp_idx_r + 4'd1;
                if (wr_idx_s == LAST_IDX) begin
                    state_nxt_s      = ST_READY;
                    keys_ready_nxt_s = 1'b1;
                    key_epoch_nxt_s  = key_epoch_r + 4'd1;
                end else begin
                    state_nxt_s = ST_LOADING;
                end
            end else begin
                state_nxt_s      = ST_ERROR;
                keys_ready_nxt_s = 1'b0;
                sched_err_nxt_s  = 1'b1;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Schedule status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_idx_r    <= 4'd0;
            keys_ready_r <= 1'b0;
            sched_err_r  <= 1'b0;
            key_epoch_r  <= 4'd0;
        end else begin
            exp_idx_r    <= exp_idx_nxt_s;
            keys_ready_r <= keys_ready_nxt_s;
            sched_err_r  <= sched_err_nxt_s;
            key_epoch_r  <= key_epoch_nxt_s;
        end
    end

    // Round key storage; only a restart or reset ever changes an entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) begin
                rk_r[i] <= 128'd0;
            end
        end else if (wr_en_s) begin
            rk_r[wr_idx_s] <= bus.key_in;
        end else begin
            rk_r[wr_idx_s] <= rk_r[wr_idx_s];
        end
    end

    // Reads sample keys_ready before the edge, so a read that coincides with
    // a restart still returns the old contents.
    assign rd_accept_s = bus.rd_req & keys_ready_r;
    assign rd_oor_s    = (bus.rd_round > LAST_IDX);
    assign rd_addr_s   = bus.rd_dir ? (LAST_IDX - bus.rd_round) : bus.rd_round;

    // Registered read port; rd_key holds when no response is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key_r       <= 128'd0;
            rd_key_valid_r <= 1'b0;
            rd_err_r       <= 1'b0;
        end else if (rd_accept_s) begin
            rd_key_valid_r <= 1'b1;
            if (rd_oor_s) begin
                rd_key_r <= 128'd0;
                rd_err_r <= 1'b1;
            end else begin
                rd_key_r <= rk_r[rd_addr_s];
                rd_err_r <= 1'b0;
            end
        end else begin
            rd_key_valid_r <= 1'b0;
            rd_err_r       <= 1'b0;
            rd_key_r       <= rd_key_r;
        end
    end

    assign bus.rd_key       = rd_key_r;
    assign bus.rd_key_valid = rd_key_valid_r;
    assign bus.rd_err       = rd_err_r;
    assign bus.keys_ready   = keys_ready_r;
    assign bus.sched_err    = sched_err_r;
    assign bus.key_epoch    = key_epoch_r;

endmodule

// File: tb/tb_aes_round_key_bank.sv
// tb_aes_round_key_bank
// Drives directed and randomized broadcast/read traffic into
// aes_round_key_bank and compares every output after every edge against a
// behavioural model of the key schedule kept in this file.
module tb_aes_round_key_bank;

    localparam int NR = 10;

    logic clk;
    logic rst_n;

    aes_round_key_bank_if #(.NUM_ROUNDS(NR)) bus ();

    aes_round_key_bank #(.NUM_ROUNDS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [127:0] m_key [0:NR];
    int           m_next;
    bit           m_loading;
    bit           m_ready;
    bit           m_err;
    logic [3:0]   m_epoch;
    logic [127:0] m_rd_key;
    bit           m_rd_valid;
    bit           m_rd_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= NR; i++) m_key[i] = 128'd0;
        m_next     = 0;
        m_loading  = 0;
        m_ready    = 0;
        m_err      = 0;
        m_epoch    = 4'd0;
        m_rd_key   = 128'd0;
        m_rd_valid = 0;
        m_rd_err   = 0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".rd_key_valid"}, 128'(bus.rd_key_valid), 128'(m_rd_valid));
        chk({where, ".rd_err"},       128'(bus.rd_err),       128'(m_rd_err));
        chk({where, ".rd_key"},       bus.rd_key,             m_rd_key);
        chk({where, ".keys_ready"},   128'(bus.keys_ready),   128'(m_ready));
        chk({where, ".sched_err"},    128'(bus.sched_err),    128'(m_err));
        chk({where, ".key_epoch"},    128'(bus.key_epoch),    128'(m_epoch));
    endtask

    // Apply one cycle of stimulus, advance the model across the edge, compare.
    task automatic step(input logic [127:0] key, input logic [NR:0] stb,
                        input logic rq, input logic [3:0] rr, input logic rdir);
        int ones;
        int k;
        @(negedge clk);
        bus.key_in         = key;
        bus.set_key_onehot = stb;
        bus.rd_req         = rq;
        bus.rd_round       = rr;
        bus.rd_dir         = rdir;
        @(posedge clk);
        #1;
        // read uses contents as they were before this edge
        if (rq && m_ready) begin
            m_rd_valid = 1;
            if (int'(rr) > NR) begin
                m_rd_key = 128'd0;
                m_rd_err = 1;
            end else begin
                m_rd_key = rdir ? m_key[NR - int'(rr)] : m_key[int'(rr)];
                m_rd_err = 0;
            end
        end else begin
            m_rd_valid = 0;
            m_rd_err   = 0;
        end
        ones = $countones(stb);
        k = 0;
        for (int i = 0; i <= NR; i++) if (stb[i]) k = i;
        if (ones > 1) begin
            m_loading = 0; m_ready = 0; m_err = 1;
        end else if (ones == 1) begin
            if (k == 0) begin
                m_key[0] = key; m_next = 1; m_loading = 1; m_ready = 0; m_err = 0;
            end else if (m_loading && k == m_next) begin
                m_key[k] = key;
                m_next++;
                if (k == NR) begin
                    m_loading = 0; m_ready = 1; m_epoch = m_epoch + 4'd1;
                end
            end else begin
                m_loading = 0; m_ready = 0; m_err = 1;
            end
        end
        check_outputs("step");
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_cycle();
        step(128'd0, '0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic load_schedule(input bit noisy);
        for (int k = 0; k <= NR; k++) begin
            if (noisy && $urandom_range(0, 3) == 0) begin
                step(rnd_key(), '0, 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            end
            step(rnd_key(), (NR+1)'(1) << k, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic random_op();
        logic [NR:0] stb;
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 4) stb = '0;
        else if (sel < 8) stb = (NR+1)'(1) << $urandom_range(0, NR);
        else stb = (NR+1)'($urandom) | (NR+1)'(3);
        step(rnd_key(), stb, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.key_in         = 128'd0;
        bus.set_key_onehot = '0;
        bus.rd_req         = 1'b0;
        bus.rd_round       = 4'd0;
        bus.rd_dir         = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // read while nothing is loaded is dropped
        step(128'd0, '0, 1'b1, 4'd2, 1'b0);
        chk("rd_not_ready", 128'(bus.rd_key_valid), 128'd0);

        // directed load: rk[i] = i
        for (int i = 0; i <= NR; i++) step(128'(i), (NR+1)'(1) << i, 1'b0, 4'd0, 1'b0);
        chk("load1.ready", 128'(bus.keys_ready), 128'd1);
        chk("load1.epoch", 128'(bus.key_epoch), 128'd1);

        step(128'd0, '0, 1'b1, 4'd3, 1'b0);
        chk("rd_enc3", bus.rd_key, 128'd3);
        step(128'd0, '0, 1'b1, 4'd3, 1'b1);
        chk("rd_dec3", bus.rd_key, 128'd7);
        step(128'd0, '0, 1'b1, 4'd11, 1'b0);
        chk("rd_oor.err", 128'(bus.rd_err), 128'd1);
        chk("rd_oor.key", bus.rd_key, 128'd0);
        idle_cycle();

        // out-of-order: 0,1,3
        step(128'hF0, (NR+1)'(1) << 0, 1'b0, 4'd0, 1'b0);
        step(128'hF1, (NR+1)'(1) << 1, 1'b0, 4'd0, 1'b0);
        step(128'hF3, (NR+1)'(1) << 3, 1'b0, 4'd0, 1'b0);
        chk("ooo.sched_err", 128'(bus.sched_err), 128'd1);
        for (int i = 0; i <= NR; i++) step(128'hA0 + 128'(i), (NR+1)'(1) << i, 1'b0, 4'd0, 1'b0);
        chk("load2.ready", 128'(bus.keys_ready), 128'd1);
        chk("load2.epoch", 128'(bus.key_epoch), 128'd2);

        // read of round 0 together with a restart returns the old rk0
        step(128'hDEAD, (NR+1)'(1), 1'b1, 4'd0, 1'b0);
        chk("rd_vs_restart.key", bus.rd_key, 128'hA0);
        chk("rd_vs_restart.ready", 128'(bus.keys_ready), 128'd0);

        // multi-hot during loading
        step(128'hBEEF, (NR+1)'(3), 1'b0, 4'd0, 1'b0);
        chk("multihot.sched_err", 128'(bus.sched_err), 128'd1);

        // randomized schedules, reads and protocol noise; epoch wraps
        for (int it = 0; it < 20; it++) begin
            load_schedule(1'b1);
            for (int r = 0; r < 6; r++)
                step(128'd0, '0, 1'b1, 4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            for (int r = 0; r < 3; r++) random_op();
        end

        // asynchronous reset in the middle of a load
        step(rnd_key(), (NR+1)'(1), 1'b0, 4'd0, 1'b0);
        step(rnd_key(), (NR+1)'(2), 1'b0, 4'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        // resuming without bit 0 is a protocol error
        step(rnd_key(), (NR+1)'(4), 1'b1, 4'd0, 1'b0);
        chk("resume.sched_err", 128'(bus.sched_err), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_round_key_bank.md
# aes_round_key_bank

Receiving end of the controller's key-broadcast interface. It captures the sequentially generated AES-128 round keys announced by a one-hot strobe and checks that they arrive in order. It stores all round keys and serves any key in encryption or decryption order through a registered read port. It sits between the AES controller and the round datapath or inverse-cipher sequencer, and it tags every completed schedule with an epoch number.

## Interface
- NUM_ROUNDS, 10, cipher rounds; the bank stores NUM_ROUNDS+1 round keys.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_in  in  128  round key being broadcast; valid only while set_key_onehot is nonzero.
- set_key_onehot  in  NUM_ROUNDS+1  bit k high means key_in is round key k.
- rd_req  in  1  read request.
- rd_round  in  4  requested round index.
- rd_dir  in  1  0 = encryption order (returns rk[r]); 1 = decryption order (returns rk[NUM_ROUNDS-r]).
- rd_key  out  128  registered read data.
- rd_key_valid  out  1  rd_key valid; one-cycle pulse.
- rd_err  out  1  qualifies rd_key_valid; set when rd_round > NUM_ROUNDS.
- keys_ready  out  1  a complete, in-order schedule is stored.
- sched_err  out  1  sticky protocol error.
- key_epoch  out  4  count of completed schedules; wraps 15 -> 0.

## Operation
- Storage: rk[0..NUM_ROUNDS], 128 bits each. Expected-index counter exp_idx is 4 bits.
- States:
  - IDLE: nothing loaded.
  - LOADING: a schedule is in progress.
  - READY: a complete schedule is stored.
  - ERROR: the last schedule was invalid.
- Strobe classification (all states):
  - zero: no action.
  - more than one bit set (multi-hot): go to ERROR, no write.
  - exactly bit k set: handled by the rules below.
- Bit 0, any state:
  - write rk[0] <= key_in, exp_idx <= 1.
  - state <= LOADING, keys_ready <= 0, sched_err <= 0.
- Bit k (k ≥ 1) in LOADING with k == exp_idx:
  - write rk[k], exp_idx <= k+1.
  - if k == NUM_ROUNDS: state <= READY, keys_ready <= 1, key_epoch <= key_epoch+1.
- Bit k (k ≥ 1) in any other case (wrong index, or arriving in IDLE, READY or ERROR):
  - state <= ERROR, keys_ready <= 0, sched_err <= 1, no write.
- ERROR is left only via bit 0 or reset.
- Reads are accepted only when keys_ready == 1 in the request cycle. A rd_req while keys_ready == 0 is dropped and produces no response.
- Read address:
  - addr = rd_dir ? NUM_ROUNDS-rd_round : rd_round.
  - rd_round > NUM_ROUNDS: rd_key = 0, rd_err = 1.
- Stored keys are never cleared except by reset. A restart overwrites them one index at a time.

## Timing
- Reset values: all rk = 0, state IDLE, exp_idx = 0, rd_key = 0, rd_key_valid = 0, rd_err = 0, keys_ready = 0, sched_err = 0, key_epoch = 0.
- Write latency: key_in is captured on the edge where its strobe is high. The controller drives key_out and set_key_onehot from the same flop stage, so no alignment stage is needed.
- keys_ready rises on the edge capturing rk[NUM_ROUNDS]. It falls on the edge capturing any bit-0 strobe or error.
- Read latency: rd_key, rd_key_valid and rd_err are registered one cycle after an accepted rd_req. Back-to-back reads sustain one per cycle. rd_key holds its last value and rd_err clears when rd_key_valid is low.
- Simultaneous read and bit-0 strobe in READY: the read is accepted and returns the pre-edge (old) contents, including the old rk[0]. keys_ready falls at the same edge.
- Reset mid-LOADING: everything returns to reset values immediately, asynchronously. A schedule resumed after reset without a bit-0 strobe goes to ERROR.
- key_epoch increments exactly once per completed schedule and wraps modulo 16.

## Test plan
- Broadcast rk0..rk10 = 128'h0..0 + i (value i in low byte) on 11 consecutive cycles -> keys_ready = 1 after 11th edge, key_epoch = 1, sched_err = 0.
- After load, rd_req with rd_round=3, rd_dir=0 then rd_round=3, rd_dir=1 back-to-back -> rd_key = 3, then 7, each with rd_key_valid = 1 one cycle later.
- rd_round=11 while ready -> rd_key_valid = 1, rd_err = 1, rd_key = 0; any rd_req with keys_ready = 0 -> no rd_key_valid.
- Strobes 0,1,3 -> sched_err = 1, state ERROR, rk[3] unchanged. Then a full 0..10 sequence -> sched_err = 0, keys_ready = 1, key_epoch incremented.
- Strobe 11'b00000000011 (multi-hot) during LOADING -> ERROR, no write to rk[0] or rk[1].
- In READY, rd_req for round 0 issued in the same cycle as a bit-0 strobe with a new key -> rd_key = old rk0, keys_ready = 0 next cycle. Then assert rst_n = 0 mid-load -> all outputs return to reset values immediately.
